// File: rtl/aes_issue.sv
// aes_issue: AES command FIFO and single-in-flight issue FSM in front of aes_ctrl.
// Optional completion timeout is built only when AES_ISSUE_TIMEOUT_EN is defined.

package aes_pkg;
    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESENCFULL      = 3'd3,
        AESKEYGENASSIST = 3'd4
    } opcode;
endpackage

module aes_issue #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 63
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  aes_pkg::opcode cmd_op_i,
    input  logic [127:0]   cmd_data_i,
    input  logic [127:0]   cmd_key_i,
    output logic           start_o,
    output aes_pkg::opcode opcode_o,
    output logic [127:0]   data_o,
    output logic [127:0]   key_o,
    input  logic           cipher_ready_i,
    input  logic           key_ready_i,
    input  logic [127:0]   result_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [127:0]   rsp_data_o,
    output aes_pkg::opcode rsp_op_o,
    output logic           rsp_err_o,
    output logic           busy_o
);
    // state | meaning
    // IDLE  | nothing in flight; pop the FIFO head when one is available
    // ISSUE | one-cycle start pulse with the registered operands
    // WAIT  | waiting for the completion pulse of the matching class
    // RESP  | response held on rsp_* until rsp_ready_i
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    state_t         state_q, state_d;
    aes_pkg::opcode fifo_op_q   [DEPTH];
    logic [127:0]   fifo_data_q [DEPTH];
    logic [127:0]   fifo_key_q  [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           ready_q;
    aes_pkg::opcode op_q, op_d, rsp_op_q, rsp_op_d;
    logic [127:0]   data_q, data_d, key_q, key_d, rsp_data_q, rsp_data_d;
    logic           push, pop, full, done;

`ifdef AES_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    // ready_q keeps cmd_ready_o low while in reset and rises one edge after release
    assign full        = (count_q == CW'(DEPTH));
    assign cmd_ready_o = ready_q && !full;
    assign push        = cmd_valid_i && cmd_ready_o && (cmd_op_i != aes_pkg::NOOP);
    assign pop         = (state_q == IDLE) && (count_q != '0);
    assign done        = (op_q == aes_pkg::AESKEYGENASSIST) ? key_ready_i : cipher_ready_i;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage is pure datapath; occupancy lives in count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q]   <= cmd_op_i;
            fifo_data_q[wr_ptr_q] <= cmd_data_i;
            fifo_key_q[wr_ptr_q]  <= cmd_key_i;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            op_q       <= aes_pkg::NOOP;
            data_q     <= '0;
            key_q      <= '0;
            rsp_data_q <= '0;
            rsp_op_q   <= aes_pkg::NOOP;
`ifdef AES_ISSUE_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            key_q      <= key_d;
            rsp_data_q <= rsp_data_d;
            rsp_op_q   <= rsp_op_d;
`ifdef AES_ISSUE_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        key_d      = key_q;
        rsp_data_d = rsp_data_q;
        rsp_op_d   = rsp_op_q;
`ifdef AES_ISSUE_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d    = fifo_op_q[rd_ptr_q];
                    data_d  = fifo_data_q[rd_ptr_q];
                    key_d   = fifo_key_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef AES_ISSUE_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // a completion landing on the timeout cycle still wins
                if (done) begin
                    rsp_data_d = result_i;
                    rsp_op_d   = op_q;
`ifdef AES_ISSUE_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = RESP;
                end
`ifdef AES_ISSUE_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_op_d   = op_q;
                    err_d      = 1'b1;
                    state_d    = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_o     = (state_q == ISSUE);
    assign opcode_o    = start_o ? op_q : aes_pkg::NOOP;
    assign data_o      = data_q;
    assign key_o       = key_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_op_o    = rsp_op_q;
    assign busy_o      = (state_q != IDLE) || (count_q != '0);
`ifdef AES_ISSUE_TIMEOUT_EN
    assign rsp_err_o   = err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_issue.sv
// Self-checking bench for aes_issue: directed scenarios plus a randomized phase,
// checked against a command-queue model and a behavioural core result function.

module tb_aes_issue;
    import aes_pkg::*;

    localparam int TIMEOUT = 63;

    typedef struct {
        opcode        op;
        logic [127:0] d;
        logic [127:0] k;
    } cmd_t;

    typedef struct {
        int           cyc;
        opcode        op;
        logic [127:0] d;
        logic [127:0] k;
    } start_t;

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         cmd_valid_i = 1'b0;
    opcode        cmd_op_i = NOOP;
    logic [127:0] cmd_data_i = '0;
    logic [127:0] cmd_key_i = '0;
    logic         cipher_ready_i = 1'b0;
    logic         key_ready_i = 1'b0;
    logic [127:0] result_i = '0;
    logic         rsp_ready_i = 1'b0;

    logic         cmd_ready_o, start_o, rsp_valid_o, rsp_err_o, busy_o;
    opcode        opcode_o, rsp_op_o;
    logic [127:0] data_o, key_o, rsp_data_o;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start = 0;
    int prev_start = -1;
    cmd_t   exp_q[$];
    start_t start_log[$];

    aes_issue #(.DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i), .cmd_key_i(cmd_key_i),
        .start_o(start_o), .opcode_o(opcode_o), .data_o(data_o), .key_o(key_o),
        .cipher_ready_i(cipher_ready_i), .key_ready_i(key_ready_i), .result_i(result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_op_o(rsp_op_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // issue monitor: logs every start pulse with the operands seen that cycle
    always @(negedge clk) begin
        if (nrst && start_o) begin
            start_t s;
            s.cyc = cyc; s.op = opcode_o; s.d = data_o; s.k = key_o;
            start_log.push_back(s);
            n_start++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // behavioural core: result depends on every operand bit and the opcode
    function automatic logic [127:0] core_fn(cmd_t c);
        return c.d ^ {c.k[63:0], c.k[127:64]} ^ {125'd0, c.op};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 0);
        check({tag, "_start"}, start_o, 0);
        check({tag, "_opcode"}, opcode_o, NOOP);
        check({tag, "_data"}, data_o, 0);
        check({tag, "_key"}, key_o, 0);
        check({tag, "_rsp_valid"}, rsp_valid_o, 0);
        check({tag, "_rsp_data"}, rsp_data_o, 0);
        check({tag, "_rsp_op"}, rsp_op_o, NOOP);
        check({tag, "_rsp_err"}, rsp_err_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic present(input opcode op, input logic [127:0] d, input logic [127:0] k);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_data_i = d; cmd_key_i = k;
    endtask

    task automatic finish_push(output int acc);
        int b = 0;
        cmd_t c;
        while (!cmd_ready_o && b < 200) begin @(negedge clk); b++; end
        check("push_ready", cmd_ready_o, 1);
        acc = cyc;
        if (cmd_op_i != NOOP) begin
            c.op = cmd_op_i; c.d = cmd_data_i; c.k = cmd_key_i;
            exp_q.push_back(c);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0; cmd_op_i = NOOP;
    endtask

    task automatic wait_start(output cmd_t e, output int s_cyc);
        int b = 0;
        start_t s;
        while (start_log.size() == 0 && b < 200) begin @(negedge clk); b++; end
        check("start_seen", start_log.size() != 0, 1);
        if (start_log.size() != 0) s = start_log.pop_front();
        else begin s.cyc = cyc; s.op = NOOP; s.d = '0; s.k = '0; end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin e.op = NOOP; e.d = '0; e.k = '0; end
        s_cyc = s.cyc;
        check("issue_op", s.op, e.op);
        check("issue_data", s.d, e.d);
        check("issue_key", s.k, e.k);
        if (prev_start >= 0) check("start_spacing", (s.cyc - prev_start) >= 5, 1);
        prev_start = s.cyc;
    endtask

    task automatic complete(input cmd_t e, input int target, input bit stray);
        int b = 0;
        while (cyc < target - 1 && b < 300) begin @(negedge clk); b++; end
        if (stray) begin
            if (e.op == AESKEYGENASSIST) cipher_ready_i = 1'b1; else key_ready_i = 1'b1;
            result_i = rnd128();
        end
        @(negedge clk);
        cipher_ready_i = 1'b0; key_ready_i = 1'b0;
        if (stray) check("stray_ignored", rsp_valid_o, 0);
        if (e.op == AESKEYGENASSIST) key_ready_i = 1'b1; else cipher_ready_i = 1'b1;
        result_i = core_fn(e);
        @(negedge clk);
        cipher_ready_i = 1'b0; key_ready_i = 1'b0; result_i = rnd128();
        check("rsp_valid_m1", rsp_valid_o, 1);
        check("rsp_data", rsp_data_o, core_fn(e));
        check("rsp_op", rsp_op_o, e.op);
        check("rsp_err", rsp_err_o, 0);
    endtask

    task automatic handshake(input opcode op, input logic [127:0] d, input logic err,
                             input int hold, output int k);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid_o, 1);
            check("hold_data", rsp_data_o, d);
            check("hold_op", rsp_op_o, op);
            check("hold_err", rsp_err_o, err);
            check("hold_no_start", start_o, 0);
            @(negedge clk);
        end
        check("hs_valid", rsp_valid_o, 1);
        check("hs_data", rsp_data_o, d);
        rsp_ready_i = 1'b1;
        k = cyc;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("hs_drop", rsp_valid_o, 0);
        check("hs_no_start_k1", start_o, 0);
    endtask

    initial begin
        cmd_t  e, ex;
        int    n_acc, s_cyc, k_cyc, base, b;
        bit    saw_valid;
        opcode op;

        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cmd_ready_o, 1);
        check("busy_after_reset", busy_o, 0);

        // single AESENC, core completes 3 cycles after start
        present(AESENC, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
        finish_push(n_acc);
        check("t1_no_start_n1", start_o, 0);
        @(negedge clk);
        check("t1_start_n2", start_o, 1);
        check("t1_opcode_n2", opcode_o, AESENC);
        @(negedge clk);
        check("t1_start_n3", start_o, 0);
        check("t1_opcode_n3", opcode_o, NOOP);
        check("t1_data_hold", data_o, 128'h00112233445566778899aabbccddeeff);
        check("t1_key_hold", key_o, 128'h000102030405060708090a0b0c0d0e0f);
        wait_start(e, s_cyc);
        check("t1_start_cycle", s_cyc, n_acc + 2);
        complete(e, s_cyc + 3, 1'b0);
        handshake(e.op, core_fn(e), 1'b0, 0, k_cyc);
        check("t1_data_after", data_o, e.d);
        check("t1_key_after", key_o, e.k);

        // key generation with a stray cipher_ready pulse
        present(AESKEYGENASSIST, rnd128(), rnd128());
        finish_push(n_acc);
        wait_start(e, s_cyc);
        complete(e, s_cyc + 5, 1'b1);
        handshake(e.op, core_fn(e), 1'b0, 1, k_cyc);

        // back-to-back pushes: full FIFO stalls, NOOP dropped, in-order responses
        base = n_start;
        present(AESENC, rnd128(), rnd128());
        finish_push(n_acc);
        wait_start(ex, s_cyc);
        present(AESENCLAST, rnd128(), rnd128());
        finish_push(n_acc);
        present(NOOP, rnd128(), rnd128());
        finish_push(n_acc);
        present(AESKEYGENASSIST, rnd128(), rnd128());
        finish_push(n_acc);
        check("t3_full_ready", cmd_ready_o, 0);
        present(AESENCFULL, rnd128(), rnd128());
        repeat (3) begin
            @(negedge clk);
            check("t3_stall", cmd_ready_o, 0);
        end
        complete(ex, cyc + 2, 1'b0);
        handshake(ex.op, core_fn(ex), 1'b0, 0, k_cyc);
        finish_push(n_acc);
        check("t3_accept_after_pop", n_acc, k_cyc + 2);
        for (int i = 0; i < 3; i++) begin
            wait_start(e, s_cyc);
            complete(e, s_cyc + 3, i == 1);
            handshake(e.op, core_fn(e), 1'b0, i, k_cyc);
        end
        check("t3_start_count", n_start - base, 4);
        check("t3_model_empty", exp_q.size(), 0);

        // response back-pressure for 10 cycles with a command waiting
        present(AESENC, rnd128(), rnd128());
        finish_push(n_acc);
        present(AESENCLAST, rnd128(), rnd128());
        finish_push(n_acc);
        wait_start(e, s_cyc);
        complete(e, s_cyc + 3, 1'b0);
        handshake(e.op, core_fn(e), 1'b0, 10, k_cyc);
        @(negedge clk);
        check("t4_start_k2", start_o, 1);
        wait_start(e, s_cyc);
        check("t4_start_cycle", s_cyc, k_cyc + 2);
        complete(e, s_cyc + 4, 1'b0);
        handshake(e.op, core_fn(e), 1'b0, 0, k_cyc);

`ifdef AES_ISSUE_TIMEOUT_EN
        // timeout with no completion, then completion on the timeout cycle
        present(AESENCFULL, rnd128(), rnd128());
        finish_push(n_acc);
        wait_start(e, s_cyc);
        b = 0;
        while (cyc < s_cyc + TIMEOUT && b < 300) begin @(negedge clk); b++; end
        check("t5_no_rsp_before", rsp_valid_o, 0);
        @(negedge clk);
        check("t5_tmo_valid", rsp_valid_o, 1);
        check("t5_tmo_err", rsp_err_o, 1);
        check("t5_tmo_data", rsp_data_o, 0);
        check("t5_tmo_op", rsp_op_o, AESENCFULL);
        handshake(AESENCFULL, 128'd0, 1'b1, 2, k_cyc);
        present(AESENC, rnd128(), rnd128());
        finish_push(n_acc);
        wait_start(e, s_cyc);
        complete(e, s_cyc + TIMEOUT, 1'b0);
        handshake(e.op, core_fn(e), 1'b0, 0, k_cyc);
`endif

        // reset during WAIT with another command queued
        present(AESENC, rnd128(), rnd128());
        finish_push(n_acc);
        wait_start(e, s_cyc);
        present(AESENCLAST, rnd128(), rnd128());
        finish_push(n_acc);
        check("t6_busy_before", busy_o, 1);
        #2 nrst = 1'b0;
        #1 check_reset_outputs("t6_async");
        exp_q.delete();
        start_log.delete();
        prev_start = -1;
        base = n_start;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("t6_ready_after", cmd_ready_o, 1);
        check("t6_fifo_empty", busy_o, 0);
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_valid = saw_valid | rsp_valid_o;
        end
        check("t6_no_rsp", saw_valid, 0);
        check("t6_no_start", n_start - base, 0);

        // randomized commands, latencies, stray pulses and back-pressure
        for (int i = 0; i < 12; i++) begin
            op = opcode'($urandom_range(0, 4));
            present(op, rnd128(), rnd128());
            finish_push(n_acc);
            if (op == NOOP) begin
                base = n_start;
                repeat (4) @(negedge clk);
                check("rnd_noop_start", n_start - base, 0);
                check("rnd_noop_busy", busy_o, 0);
            end else begin
                wait_start(e, s_cyc);
                complete(e, s_cyc + int'($urandom_range(3, 8)), $urandom_range(0, 1) == 1);
                handshake(e.op, core_fn(e), 1'b0, int'($urandom_range(0, 3)), k_cyc);
            end
        end

        repeat (3) @(negedge clk);
        check("final_no_extra_start", start_log.size(), 0);
        check("final_idle", busy_o, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
